result_frame_tx: RTL and testbench

//  Packs an N-channel inference result vector into a framed byte stream and

---
 rtl/result_frame_tx.sv | 156 +++++++++++++++
 tb/tb_result_frame_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : result_frame_tx
// Purpose  : Frames an N-channel result vector (header + payload [+ checksum])
//            onto the uart_send byte interface, one byte per busy cycle.
// Options  : RESULT_TX_CHECKSUM_EN appends an XOR checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module result_frame_tx #(
    parameter int         NUM_CH   = 10,
    parameter int         CH_W     = 8,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   res_valid,
    input  logic [NUM_CH*CH_W-1:0] res_data,
    output logic                   res_ready,
    output logic                   uart_en,
    output logic [7:0]             uart_din,
    input  logic                   uart_tx_busy,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam int NBYTES = NUM_CH * CH_W / 8;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int FRAME_LEN = NBYTES + 2;
`else
    localparam int FRAME_LEN = NBYTES + 1;
`endif
    localparam int             IDX_W    = $clog2(NBYTES + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_CH*CH_W-1:0] shadow_q, shadow_d;
    logic                   ready_q, ready_d;
    logic                   accept;
    logic [7:0]             cur_byte;

`ifdef RESULT_TX_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // Checksum is computed once from the incoming vector at acceptance.
    always_comb begin
        csum_d = csum_q;
        if (accept) begin
            csum_d = HDR_BYTE;
            for (int b = 0; b < NBYTES; b++) begin
                csum_d = csum_d ^ res_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // Index 0 is the header, 1..NBYTES the payload LSB-first, then checksum.
    always_comb begin
        cur_byte = HDR_BYTE;
        for (int b = 0; b < NBYTES; b++) begin
            if (idx_q == IDX_W'(b + 1)) begin
                cur_byte = shadow_q[b*8 +: 8];
            end
        end
`ifdef RESULT_TX_CHECKSUM_EN
        if (idx_q == LAST_IDX) begin
            cur_byte = csum_q;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        uart_en    = 1'b0;
        uart_din   = 8'h00;
        frame_done = 1'b0;
        accept     = res_valid && ready_q;
        overrun    = res_valid && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = SEND;
                    idx_d    = '0;
                    shadow_d = res_data;
                end
            end
            SEND: begin
                uart_en  = 1'b1;
                uart_din = cur_byte;
                state_d  = WAIT_HI;
            end
            WAIT_HI: begin
                if (uart_tx_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!uart_tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = SEND;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered so that ready stays low while reset is asserted.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            ready_q  <= ready_d;
        end
    end

    assign res_ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_result_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_frame_tx
// Purpose  : Directed self-checking bench for result_frame_tx with a
//            behavioural uart_send (busy 1 cycle after en, high 20 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_frame_tx;

`ifdef RESULT_TX_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int FLEN_A = 11 + CS;
    localparam int FLEN_B = 9 + CS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        res_valid_a = 1'b0, res_ready_a, uart_en_a, busy_a, frame_done_a, overrun_a;
    logic [79:0] res_data_a = '0;
    logic [7:0]  uart_din_a;
    logic        res_valid_b = 1'b0, res_ready_b, uart_en_b, busy_b, frame_done_b, overrun_b;
    logic [63:0] res_data_b = '0;
    logic [7:0]  uart_din_b;

    result_frame_tx #(.NUM_CH(10), .CH_W(8), .HDR_BYTE(8'hA5)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .res_valid(res_valid_a), .res_data(res_data_a),
        .res_ready(res_ready_a), .uart_en(uart_en_a), .uart_din(uart_din_a),
        .uart_tx_busy(busy_a), .frame_done(frame_done_a), .overrun(overrun_a)
    );

    result_frame_tx #(.NUM_CH(4), .CH_W(16), .HDR_BYTE(8'hA5)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .res_valid(res_valid_b), .res_data(res_data_b),
        .res_ready(res_ready_b), .uart_en(uart_en_b), .uart_din(uart_din_b),
        .uart_tx_busy(busy_b), .frame_done(frame_done_b), .overrun(overrun_b)
    );

    // uart_send models
    int   cnt_a = 0, cnt_b = 0;
    logic hold_a = 1'b0;
    always @(posedge clk) begin
        if (uart_en_a) cnt_a <= 20;
        else if (cnt_a > 0) cnt_a <= cnt_a - 1;
        if (uart_en_b) cnt_b <= 20;
        else if (cnt_b > 0) cnt_b <= cnt_b - 1;
    end
    assign busy_a = (cnt_a > 0) || hold_a;
    assign busy_b = (cnt_b > 0);

    logic [7:0] cap_a[$];
    logic [7:0] cap_b[$];
    int done_a = 0, ovr_a = 0, acc_a = 0, done_b = 0;
    always @(negedge clk) begin
        if (uart_en_a) cap_a.push_back(uart_din_a);
        if (frame_done_a) done_a++;
        if (overrun_a) ovr_a++;
        if (res_valid_a && res_ready_a) acc_a++;
        if (uart_en_b) cap_b.push_back(uart_din_b);
        if (frame_done_b) done_b++;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cap_a_at(input int i);
        return (i < cap_a.size()) ? 32'(cap_a[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] cap_b_at(input int i);
        return (i < cap_b.size()) ? 32'(cap_b[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic clr();
        cap_a.delete();
        cap_b.delete();
        done_a = 0; ovr_a = 0; acc_a = 0; done_b = 0;
    endtask

    task automatic send_a(input logic [79:0] d);
        @(posedge clk); #1 res_data_a = d; res_valid_a = 1'b1;
        @(posedge clk); #1 res_valid_a = 1'b0;
    endtask

    task automatic wait_done_a(input int target, input string tag);
        int t = 0;
        while (done_a < target && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check(tag, 32'(done_a), 32'(target));
    endtask

    task automatic wait_en_a(input int target);
        int n = 0;
        int t = 0;
        while (n < target && t < 2000) begin
            @(negedge clk);
            if (uart_en_a) n++;
            t++;
        end
        check("wait_en", 32'(n), 32'(target));
    endtask

    logic [79:0] d1 = 80'h09080706050403020100;
    logic [7:0]  exp6 [0:9] = '{8'hA5, 8'h0E, 8'h0F, 8'hAA, 8'hBB,
                                8'h11, 8'h22, 8'h33, 8'h44, 8'hF1};

    initial begin
        int n;
        logic [31:0] e;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(res_ready_a), 0);
        check("rst_en", 32'(uart_en_a), 0);
        check("rst_din", 32'(uart_din_a), 0);
        check("rst_done", 32'(frame_done_a), 0);
        check("rst_ovr", 32'(overrun_a), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_ready", 32'(res_ready_a), 1);

        // 1: basic frame
        clr();
        send_a(d1);
        @(negedge clk);
        check("t1_first_en", 32'(uart_en_a), 1);
        check("t1_first_din", 32'(uart_din_a), 32'hA5);
        check("t1_ready_low", 32'(res_ready_a), 0);
        wait_done_a(1, "t1_done");
        repeat (3) @(posedge clk);
        check("t1_len", 32'(cap_a.size()), 32'(FLEN_A));
        for (int i = 0; i < FLEN_A; i++) begin
            e = (i == 0) ? 32'hA5 : ((i <= 10) ? 32'(i - 1) : 32'hA4);
            check("t1_byte", cap_a_at(i), e);
        end
        check("t1_done_cnt", 32'(done_a), 1);
        check("t1_ovr", 32'(ovr_a), 0);

        // 2: valid held through a whole frame
        clr();
        @(posedge clk); #1 res_data_a = 80'hFFEEDDCCBBAA99887766; res_valid_a = 1'b1;
        n = 0;
        while (acc_a < 2 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1 res_valid_a = 1'b0;
        check("t2_acc", 32'(acc_a), 2);
        check("t2_done_before_acc2", 32'(done_a), 1);
        check("t2_ovr", 32'(ovr_a), 32'(FLEN_A * 22 + 1));
        wait_done_a(2, "t2_done");
        repeat (3) @(posedge clk);
        check("t2_len", 32'(cap_a.size()), 32'(2 * FLEN_A));
        check("t2_hdr1", cap_a_at(0), 32'hA5);
        check("t2_b1", cap_a_at(1), 32'h66);
        check("t2_b10", cap_a_at(10), 32'hFF);
        check("t2_hdr2", cap_a_at(FLEN_A), 32'hA5);
        check("t2_f2_b1", cap_a_at(FLEN_A + 1), 32'h66);
        check("t2_ovr_after", 32'(ovr_a), 32'(FLEN_A * 22 + 1));

        // 3: all-zero vector is transmitted
        clr();
        send_a(80'h0);
        wait_done_a(1, "t3_done");
        repeat (3) @(posedge clk);
        check("t3_len", 32'(cap_a.size()), 32'(FLEN_A));
        for (int i = 0; i < FLEN_A; i++) begin
            e = (i == 0 || i == 11) ? 32'hA5 : 32'h0;
            check("t3_byte", cap_a_at(i), e);
        end

        // 4: reset during the fourth byte
        clr();
        send_a(d1);
        wait_en_a(4);
        check("t4_byte4", 32'(uart_din_a), 32'h02);
        #1 rst_n = 1'b0;
        #1;
        check("t4_rst_en", 32'(uart_en_a), 0);
        check("t4_rst_din", 32'(uart_din_a), 0);
        check("t4_rst_ready", 32'(res_ready_a), 0);
        check("t4_rst_done", 32'(frame_done_a), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_ready", 32'(res_ready_a), 1);
        repeat (100) @(posedge clk);
        check("t4_no_more", 32'(cap_a.size()), 4);
        check("t4_no_done", 32'(done_a), 0);

        // 5: busy stretched to 500 cycles on one byte
        clr();
        send_a(d1);
        wait_en_a(2);
        hold_a = 1'b1;
        n = 0;
        repeat (500) begin
            @(negedge clk);
            if (uart_en_a) n++;
        end
        check("t5_no_en", 32'(n), 0);
        @(posedge clk); #1 hold_a = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!uart_en_a && n < 20);
        check("t5_gap", 32'(n), 2);
        check("t5_din", 32'(uart_din_a), 32'h01);
        wait_done_a(1, "t5_done");
        repeat (3) @(posedge clk);
        check("t5_len", 32'(cap_a.size()), 32'(FLEN_A));

        // 6: 4 x 16-bit channels
        clr();
        @(posedge clk); #1 res_data_b = 64'h4433_2211_BBAA_0F0E; res_valid_b = 1'b1;
        @(posedge clk); #1 res_valid_b = 1'b0;
        n = 0;
        while (done_b < 1 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("t6_done", 32'(done_b), 1);
        repeat (3) @(posedge clk);
        check("t6_len", 32'(cap_b.size()), 32'(FLEN_B));
        for (int i = 0; i < FLEN_B; i++) begin
            check("t6_byte", cap_b_at(i), 32'(exp6[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
